// File: rtl/phase_unwrapper_pkg.sv
// Shared vibrometer constants: default stream widths and the signed limits of
// the default accumulator width.
package phase_unwrapper_pkg;

    localparam int unsigned PHASE_WIDTH_DEF      = 16;
    localparam int unsigned AXIS_TDATA_WIDTH_DEF = 32;

    localparam logic signed [AXIS_TDATA_WIDTH_DEF-1:0] AXIS_MAX_DEF =
        {1'b0, {(AXIS_TDATA_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [AXIS_TDATA_WIDTH_DEF-1:0] AXIS_MIN_DEF =
        {1'b1, {(AXIS_TDATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/phase_unwrapper_sat_add.sv
// Combinational signed adder that clamps to the W-bit signed range and flags
// when clamping occurred.
module phase_unwrapper_sat_add #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    // One guard bit: the top two bits disagree exactly when the true sum leaves the range.
    always_comb begin
        wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        sum_o = wide[W-1:0];
        ovf_o = 1'b0;
        if (wide[W] != wide[W-1]) begin
            ovf_o = 1'b1;
            sum_o = wide[W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/phase_unwrapper.sv
// Turns a wrapped phase stream into a continuous signed displacement using a
// two-stage AXI-Stream pipeline with a saturating accumulator.
module phase_unwrapper
    import phase_unwrapper_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH      = PHASE_WIDTH_DEF,
    parameter int unsigned AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_reset,
    input  logic                        PU_clear,
    input  logic [PHASE_WIDTH-1:0]      S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        PU_overflow
);

    localparam int unsigned PW  = PHASE_WIDTH;
    localparam int unsigned AW  = AXIS_TDATA_WIDTH;
    localparam int unsigned EXT = AW - PW;

    // Stage 1 state
    logic          v1_q, v1_d;
    logic          first_q, first_d;
    logic          is_first_q, is_first_d;
    logic [PW-1:0] prev_q, prev_d;
    logic [PW-1:0] delta_q, delta_d;
    logic [PW-1:0] phase_q, phase_d;

    // Stage 2 state
    logic [AW-1:0] acc_q, acc_d;
    logic          m_valid_q, m_valid_d;
    logic          ovf_q, ovf_d;

    logic          adv;
    logic          hs;
    logic [AW-1:0] delta_ext;
    logic [AW-1:0] phase_ext;
    logic [AW-1:0] sum;
    logic          sum_ovf;

    assign adv           = ~m_valid_q | M_AXIS_tready;
    assign S_AXIS_tready = adv & ~PU_clear & ~SYS_reset;
    assign hs            = S_AXIS_tvalid & S_AXIS_tready;

    assign delta_ext = {{EXT{delta_q[PW-1]}}, delta_q};
    assign phase_ext = {{EXT{phase_q[PW-1]}}, phase_q};

    phase_unwrapper_sat_add #(
        .W (AW)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (delta_ext),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    // Stage 1: modular difference against the previously accepted sample.
    always_comb begin
        v1_d       = v1_q;
        first_d    = first_q;
        is_first_d = is_first_q;
        prev_d     = prev_q;
        delta_d    = delta_q;
        phase_d    = phase_q;
        if (PU_clear) begin
            v1_d    = 1'b0;
            first_d = 1'b1;
            prev_d  = '0;
        end else if (adv) begin
            if (hs) begin
                v1_d       = 1'b1;
                delta_d    = S_AXIS_tdata - prev_q;
                phase_d    = S_AXIS_tdata;
                prev_d     = S_AXIS_tdata;
                is_first_d = first_q;
                first_d    = 1'b0;
            end else begin
                v1_d = 1'b0;
            end
        end
    end

    // Stage 2: seed with the raw first phase, then accumulate with saturation.
    always_comb begin
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        ovf_d     = ovf_q;
        if (PU_clear) begin
            acc_d     = '0;
            m_valid_d = 1'b0;
            ovf_d     = 1'b0;
        end else if (adv) begin
            if (v1_q) begin
                m_valid_d = 1'b1;
                if (is_first_q) begin
                    acc_d = phase_ext;
                end else begin
                    acc_d = sum;
                    ovf_d = ovf_q | sum_ovf;
                end
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            v1_q       <= 1'b0;
            first_q    <= 1'b1;
            is_first_q <= 1'b0;
            prev_q     <= '0;
            delta_q    <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            m_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            first_q    <= first_d;
            is_first_q <= is_first_d;
            prev_q     <= prev_d;
            delta_q    <= delta_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            m_valid_q  <= m_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign M_AXIS_tdata  = acc_q;
    assign M_AXIS_tvalid = m_valid_q;
    assign PU_overflow   = ovf_q;

endmodule

// File: tb/tb_phase_unwrapper.sv
// Directed bench for phase_unwrapper with a 20-bit accumulator so saturation
// is reachable in a short ramp.
module tb_phase_unwrapper;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [PW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [AW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          ovf;

    int errors = 0;
    int checks = 0;
    int ins_a[32];
    int exp_a[32];

    always #5 clk = ~clk;

    phase_unwrapper #(
        .PHASE_WIDTH      (PW),
        .AXIS_TDATA_WIDTH (AW)
    ) dut (
        .SYS_aclk      (clk),
        .SYS_reset     (rst),
        .PU_clear      (clr),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .PU_overflow   (ovf)
    );

    function automatic int out_val();
        logic signed [AW-1:0] s;
        s = $signed(m_tdata);
        return int'(s);
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams ins_a[0..n-1]; stalls M_AXIS_tready for st_len cycles from st_beg.
    task automatic run_stream(input string tag, input int n, input int st_beg, input int st_len);
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        int held = 0;
        logic stalled_prev = 1'b0;
        while (oi < n && cyc < 200) begin
            s_tvalid = (ii < n);
            s_tdata  = (ii < n) ? PW'(ins_a[ii]) : '0;
            m_tready = !(cyc >= st_beg && cyc < st_beg + st_len);
            #1;
            chk({tag, "_sready"}, int'(s_tready), int'(!(m_tvalid && !m_tready)));
            if (stalled_prev) chk({tag, "_hold"}, out_val(), held);
            if (m_tvalid && m_tready) begin
                chk({tag, "_data"}, out_val(), exp_a[oi]);
                if (st_len == 0) chk({tag, "_latency"}, cyc, oi + 2);
                oi++;
            end
            if (s_tvalid && s_tready) ii++;
            stalled_prev = m_tvalid && !m_tready;
            held         = out_val();
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk({tag, "_count"}, oi, n);
    endtask

    task automatic pulse_clear(input string tag);
        clr      = 1'b1;
        s_tvalid = 1'b0;
        #1;
        chk({tag, "_sready"}, int'(s_tready), 0);
        tick();
        chk({tag, "_mvalid"}, int'(m_tvalid), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        clr = 1'b0;
    endtask

    initial begin
        int acc;
        logic [PW-1:0] w;

        rst      = 1'b1;
        clr      = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_tdata", out_val(), 0);
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_sready", int'(s_tready), 0);
        rst = 1'b0;
        #1;
        chk("rst_release_sready", int'(s_tready), 1);
        tick();

        // Positive wrap
        ins_a[0] = 0;     exp_a[0] = 0;
        ins_a[1] = 10000; exp_a[1] = 10000;
        ins_a[2] = 20000; exp_a[2] = 20000;
        ins_a[3] = 30000; exp_a[3] = 30000;
        ins_a[4] = -25536; exp_a[4] = 40000;
        run_stream("poswrap", 5, 0, 0);
        tick();
        chk("poswrap_drain", int'(m_tvalid), 0);

        // Negative wrap after a soft restart
        pulse_clear("clr1");
        ins_a[0] = -30000; exp_a[0] = -30000;
        ins_a[1] = 30000;  exp_a[1] = -35536;
        ins_a[2] = 0;      exp_a[2] = -65536;
        run_stream("negwrap", 3, 0, 0);

        // Half-turn step resolves negative
        pulse_clear("clr2");
        ins_a[0] = 16384;  exp_a[0] = 16384;
        ins_a[1] = -16384; exp_a[1] = -16384;
        ins_a[2] = 16384;  exp_a[2] = -49152;
        run_stream("halfturn", 3, 0, 0);

        // Backpressure mid-stream
        pulse_clear("clr3");
        for (int i = 0; i < 6; i++) begin
            ins_a[i] = i + 1;
            exp_a[i] = i + 1;
        end
        run_stream("bp", 6, 3, 3);

        // Saturation ramp in +30000 steps, then a -10000 step
        pulse_clear("clr4");
        acc = 0;
        for (int k = 0; k < 19; k++) begin
            w        = PW'(k * 30000);
            ins_a[k] = int'($signed(w));
            if (k > 0) acc = (acc + 30000 > 524287) ? 524287 : acc + 30000;
            exp_a[k] = acc;
        end
        w         = PW'(ins_a[18] - 10000);
        ins_a[19] = int'($signed(w));
        exp_a[19] = 514287;
        run_stream("sat", 20, 0, 0);
        chk("sat_ovf", int'(ovf), 1);

        // Pending stalled output, then clear overrides it
        m_tready = 1'b0;
        s_tdata  = PW'(ins_a[19] + 100);
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        tick();
        chk("stall_valid", int'(m_tvalid), 1);
        chk("stall_data", out_val(), 514387);
        tick();
        chk("stall_held", out_val(), 514387);
        chk("stall_sready", int'(s_tready), 0);
        chk("stall_ovf", int'(ovf), 1);
        clr = 1'b1;
        #1;
        chk("clr5_sready", int'(s_tready), 0);
        tick();
        chk("clr5_mvalid", int'(m_tvalid), 0);
        chk("clr5_ovf", int'(ovf), 0);
        tick();
        chk("clr5_tdata", out_val(), 0);
        clr      = 1'b0;
        m_tready = 1'b1;
        ins_a[0] = 5000; exp_a[0] = 5000;
        run_stream("postclr", 1, 0, 0);
        chk("postclr_ovf", int'(ovf), 0);

        // Reset with samples in flight
        s_tdata  = PW'(11);
        s_tvalid = 1'b1;
        tick();
        s_tdata = PW'(22);
        tick();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        tick();
        chk("midrst_mvalid", int'(m_tvalid), 0);
        chk("midrst_tdata", out_val(), 0);
        rst = 1'b0;
        ins_a[0] = 777; exp_a[0] = 777;
        ins_a[1] = 787; exp_a[1] = 787;
        run_stream("midrst", 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
